// File: rtl/shift_reg_pkg.sv
// Shared encodings for the shift-register sequencer and its datapath wrapper:
// register mode codes and the sequencer state type.
package shift_reg_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_SHR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // dir 0 moves data toward the MSB, dir 1 toward the LSB
    function automatic logic [1:0] shift_sel(input logic dir);
        return dir ? SEL_SHR : SEL_SHL;
    endfunction

endpackage

// File: rtl/seq_counter.sv
// CW-bit up-counter with synchronous clear and enable, plus a terminal
// compare flag that is high while the count equals the supplied limit.
module seq_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] len,
    output logic [CW-1:0] count,
    output logic          term
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign term  = (count_q == len);

endmodule

// File: rtl/shift_reg_seq.sv
// Command sequencer for the N-bit shift register: optional load cycle, then a
// programmed number of shift cycles, then a one-cycle done pulse.
module shift_reg_seq #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cmd_load,
    input  logic          cmd_dir,
    input  logic [CW-1:0] cmd_len,
    input  logic          abort,
    output logic [1:0]    selection,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] shift_cnt
);

    import shift_reg_pkg::*;

    state_t        state_q, state_d;
    logic          dir_q, dir_d;
    logic [CW-1:0] len_q, len_d;
    logic [1:0]    sel_q, sel_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [CW-1:0] sat_len;
    logic [CW-1:0] len_last;
    logic          cnt_clr;
    logic          cnt_en;
    logic          cnt_term;

    assign sat_len = (cmd_len > CW'(N)) ? CW'(N) : cmd_len;

    // The counter flags the final shift cycle, so the compare limit is len-1;
    // it is only consulted in SHIFT, where len is known to be non-zero.
    assign len_last = len_q - CW'(1);

    seq_counter #(.CW(CW)) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .len   (len_last),
        .count (shift_cnt),
        .term  (cnt_term)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        len_d   = len_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    dir_d   = cmd_dir;
                    len_d   = sat_len;
                    cnt_clr = 1'b1;
                    if (cmd_load) begin
                        state_d = ST_LOAD;
                    end else if (sat_len != '0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (len_q != '0) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_term) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered with it
        sel_d  = SEL_HOLD;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        case (state_d)
            ST_LOAD:  sel_d = SEL_LOAD;
            ST_SHIFT: sel_d = shift_sel(dir_d);
            default:  sel_d = SEL_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            len_q   <= '0;
            sel_q   <= SEL_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            len_q   <= len_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign selection = sel_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
